// File: rtl/coherence_bus_ctrl.sv
// MSI snoopy-bus controller/arbiter between two cores' L1 caches and a single-port RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise core 0 always wins ties.
module coherence_bus_ctrl #(
    parameter int WORD_W        = 32,
    parameter int SNOOP_TIMEOUT = 15
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             iREN,
    input  logic [1:0][WORD_W-1:0] iaddr,
    output logic [1:0]             iwait,
    output logic [1:0][WORD_W-1:0] iload,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    output logic [1:0]             dwait,
    output logic [1:0][WORD_W-1:0] dload,
    input  logic [1:0]             cctrans,
    input  logic [1:0]             ccwrite,
    output logic [1:0]             ccwait,
    output logic [1:0]             ccinv,
    output logic [1:0][WORD_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic [1:0]             ramstate
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WB     = 3'd1;
    localparam logic [2:0] ST_SNOOP  = 3'd2;
    localparam logic [2:0] ST_C2C    = 3'd3;
    localparam logic [2:0] ST_FILL   = 3'd4;
    localparam logic [2:0] ST_IFETCH = 3'd5;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] TMO_LIMIT  = 4'(SNOOP_TIMEOUT);

    logic [2:0] r_state;
    logic       r_core;
    logic       r_blk;
    logic       r_rr;
    logic [3:0] r_tmo;

    logic [2:0] w_nextState;
    logic       w_grantCore;
    logic       w_peer;
    logic       w_access;
    logic       w_active;
    logic       w_twoWord;
    logic       w_blockDone;

    function automatic logic pickCore(input logic [1:0] req, input logic tie);
        if (req == 2'b11) begin
            return tie;
        end
        return req[1];
    endfunction

    assign w_peer    = ~r_core;
    assign w_access  = (ramstate == RAM_ACCESS);
    assign w_twoWord = (r_state == ST_WB) || (r_state == ST_C2C) || (r_state == ST_FILL);

    // The owner must hold its request for the whole transaction; dropping it aborts.
    always_comb begin
        w_active = 1'b0;
        case (r_state)
            ST_WB:                     w_active = dWEN[r_core];
            ST_SNOOP, ST_C2C, ST_FILL: w_active = dREN[r_core];
            ST_IFETCH:                 w_active = iREN[r_core];
            default:                   w_active = 1'b0;
        endcase
    end

    assign w_blockDone = w_active && w_access &&
                         ((r_state == ST_IFETCH) || (w_twoWord && r_blk));

    always_comb begin
        w_nextState = r_state;
        w_grantCore = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|dWEN) begin
                    w_grantCore = pickCore(dWEN, r_rr);
                    w_nextState = ST_WB;
                end else if (|dREN) begin
                    w_grantCore = pickCore(dREN, r_rr);
                    w_nextState = cctrans[w_grantCore] ? ST_SNOOP : ST_FILL;
                end else if (|iREN) begin
                    w_grantCore = pickCore(iREN, r_rr);
                    w_nextState = ST_IFETCH;
                end
            end
            ST_SNOOP: begin
                if (!w_active) begin
                    w_nextState = ST_IDLE;
                end else if (cctrans[w_peer] && ccwrite[w_peer]) begin
                    w_nextState = ST_C2C;
                end else if (cctrans[w_peer] || (r_tmo == TMO_LIMIT)) begin
                    w_nextState = ST_FILL;
                end
            end
            ST_WB, ST_C2C, ST_FILL, ST_IFETCH: begin
                if (!w_active || w_blockDone) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_core  <= 1'b0;
            r_blk   <= 1'b0;
            r_tmo   <= 4'd0;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_IDLE) begin
                r_core <= w_grantCore;
                r_blk  <= 1'b0;
                r_tmo  <= 4'd0;
            end else begin
                if (r_state == ST_SNOOP) begin
                    r_tmo <= r_tmo + 4'd1;
                end
                if (w_twoWord && w_active && w_access) begin
                    r_blk <= ~r_blk;
                end
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (w_blockDone) begin
                r_rr <= ~r_core;
            end
`else
            r_rr <= 1'b0;
`endif
        end
    end

    // In a cache-to-cache transfer the peer's dirty words go to RAM and to the requester at once.
    always_comb begin
        iwait       = 2'b11;
        dwait       = 2'b11;
        iload       = '0;
        dload       = '0;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        if (w_active) begin
            case (r_state)
                ST_WB: begin
                    ramWEN        = 1'b1;
                    ramaddr       = daddr[r_core];
                    ramstore      = dstore[r_core];
                    dwait[r_core] = ~w_access;
                end
                ST_SNOOP: begin
                    ccwait[w_peer]      = 1'b1;
                    ccsnoopaddr[w_peer] = daddr[r_core];
                    ccinv[w_peer]       = ccwrite[r_core];
                end
                ST_C2C: begin
                    ccwait[w_peer] = 1'b1;
                    ramWEN         = 1'b1;
                    ramaddr        = daddr[w_peer];
                    ramstore       = dstore[w_peer];
                    dload[r_core]  = dstore[w_peer];
                    if (w_access) begin
                        dwait[r_core] = 1'b0;
                        dwait[w_peer] = 1'b0;
                    end
                end
                ST_FILL: begin
                    ramREN        = 1'b1;
                    ramaddr       = daddr[r_core];
                    dload[r_core] = ramload;
                    dwait[r_core] = ~w_access;
                end
                ST_IFETCH: begin
                    ramREN        = 1'b1;
                    ramaddr       = iaddr[r_core];
                    iload[r_core] = ramload;
                    iwait[r_core] = ~w_access;
                end
                default: begin
                    ramREN = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: stimulus pushes expected RAM word transfers,
// a negedge monitor pops and compares them; honours ARB_ROUND_ROBIN_EN like the design.
module tb_coherence_bus_ctrl;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        isI;
        logic        core;
        logic [31:0] rdata;
        logic [1:0]  expIwait;
        logic [1:0]  expDwait;
    } xfer_t;

    logic             CLK;
    logic             RST;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       dwait;
    logic [1:0][31:0] dload;
    logic [1:0]       cctrans;
    logic [1:0]       ccwrite;
    logic [1:0]       ccwait;
    logic [1:0]       ccinv;
    logic [1:0][31:0] ccsnoopaddr;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic [1:0]       ramstate;

    int    errors = 0;
    int    checks = 0;
    xfer_t expQ[$];
    xfer_t monExp;

    coherence_bus_ctrl #(.WORD_W(32), .SNOOP_TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] rs, input logic [31:0] rl);
        ramstate = rs;
        ramload  = rl;
        nextCycle();
    endtask

    task automatic pushExp(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic isI, input logic core, input logic [31:0] rdata,
                           input logic [1:0] iw, input logic [1:0] dw);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.wdata = wdata; x.isI = isI; x.core = core;
        x.rdata = rdata; x.expIwait = iw; x.expDwait = dw;
        expQ.push_back(x);
    endtask

    // Every completed RAM word must match the oldest expected transfer.
    initial forever begin
        @(negedge CLK);
        if (!RST && ramstate == RS_ACCESS && (ramREN || ramWEN)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_xfer: ramaddr %h transferred, expected none", ramaddr);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("xfer_wen", 32'(ramWEN), 32'(monExp.wr));
                checkOutput("xfer_ren", 32'(ramREN), 32'(!monExp.wr));
                checkOutput("xfer_addr", ramaddr, monExp.addr);
                if (monExp.wr) checkOutput("xfer_store", ramstore, monExp.wdata);
                checkOutput("xfer_iwait", 32'(iwait), 32'(monExp.expIwait));
                checkOutput("xfer_dwait", 32'(dwait), 32'(monExp.expDwait));
                checkOutput("xfer_data", monExp.isI ? iload[monExp.core] : dload[monExp.core],
                            monExp.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time %0t reached, expected completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    grantOrder[3];
        int    nBlk[2];
        int    blkTotal[2];
        int    snoopCycles;
        logic  found;
        logic  c;
        logic [31:0] a;
        logic [31:0] d;

        RST = 1'b1; iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
        cctrans = '0; ccwrite = '0; ramload = '0; ramstate = RS_FREE;

        // Reset
        nextCycle();
        nextCycle();
        @(negedge CLK);
        checkOutput("rst_iwait", 32'(iwait), 32'(2'b11));
        checkOutput("rst_dwait", 32'(dwait), 32'(2'b11));
        checkOutput("rst_ccwait", 32'(ccwait), 32'(2'b00));
        checkOutput("rst_ccinv", 32'(ccinv), 32'(2'b00));
        checkOutput("rst_ramREN", 32'(ramREN), 32'(1'b0));
        checkOutput("rst_ramWEN", 32'(ramWEN), 32'(1'b0));
        nextCycle();
        RST = 1'b0;
        nextCycle();

        // Core 0 icache fetch, two BUSY cycles then ACCESS
        iREN[0] = 1'b1; iaddr[0] = 32'h40; ramload = 32'hDEADBEEF;
        nextCycle();
        ramstate = RS_BUSY;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            checkOutput("ifetch_busy_ren", 32'(ramREN), 32'(1'b1));
            checkOutput("ifetch_busy_addr", ramaddr, 32'h40);
            checkOutput("ifetch_busy_iwait", 32'(iwait), 32'(2'b11));
            nextCycle();
        end
        pushExp(1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 2'b10, 2'b11);
        applyStimulus(RS_ACCESS, 32'hDEADBEEF);
        iREN = '0; ramstate = RS_FREE;
        @(negedge CLK);
        checkOutput("ifetch_done_ren", 32'(ramREN), 32'(1'b0));
        nextCycle();

        // Core 1 icache fetch with an ERROR stall
        iREN[1] = 1'b1; iaddr[1] = 32'h80; ramload = 32'h12345678;
        nextCycle();
        ramstate = RS_ERROR;
        @(negedge CLK);
        checkOutput("ifetch_err_iwait", 32'(iwait), 32'(2'b11));
        checkOutput("ifetch_err_addr", ramaddr, 32'h80);
        nextCycle();
        pushExp(1'b0, 32'h80, 32'h0, 1'b1, 1'b1, 32'h12345678, 2'b01, 2'b11);
        applyStimulus(RS_ACCESS, 32'h12345678);
        iREN = '0; ramstate = RS_FREE;
        nextCycle();

        // Core 0 coherent fill, core 1 holds the block dirty
        dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b0; daddr[0] = 32'h100;
        nextCycle();
        @(negedge CLK);
        checkOutput("snoop_ccwait", 32'(ccwait), 32'(2'b10));
        checkOutput("snoop_addr", ccsnoopaddr[1], 32'h100);
        checkOutput("snoop_ccinv", 32'(ccinv), 32'(2'b00));
        checkOutput("snoop_no_ram", 32'(ramREN | ramWEN), 32'(1'b0));
        nextCycle();
        cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h100; dstore[1] = 32'h11;
        nextCycle();
        pushExp(1'b1, 32'h100, 32'h11, 1'b0, 1'b0, 32'h11, 2'b11, 2'b00);
        ramstate = RS_ACCESS;
        @(negedge CLK);
        checkOutput("c2c_ccwait", 32'(ccwait), 32'(2'b10));
        nextCycle();
        daddr[1] = 32'h104; dstore[1] = 32'h22;
        pushExp(1'b1, 32'h104, 32'h22, 1'b0, 1'b0, 32'h22, 2'b11, 2'b00);
        nextCycle();
        dREN = '0; cctrans = '0; ccwrite = '0; ramstate = RS_FREE;
        nextCycle();

        // Core 1 fill with intent to modify, core 0 never answers
        dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h200;
        nextCycle();
        snoopCycles = 0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                checkOutput("tmo_ccinv", 32'(ccinv), 32'(2'b01));
                checkOutput("tmo_ccwait", 32'(ccwait), 32'(2'b01));
                checkOutput("tmo_snoopaddr", ccsnoopaddr[0], 32'h200);
            end
            if (ramREN) begin
                found = 1'b1;
                break;
            end
            if (ccwait == 2'b01) snoopCycles++;
            nextCycle();
        end
        checkOutput("tmo_fill_reached", 32'(found), 32'(1'b1));
        checkOutput("tmo_window", 32'((snoopCycles == 15) || (snoopCycles == 16)), 32'(1'b1));
        if (found) begin
            checkOutput("tmo_fill_ccwait", 32'(ccwait), 32'(2'b00));
            nextCycle();
            pushExp(1'b0, 32'h200, 32'h0, 1'b0, 1'b1, 32'hA1, 2'b11, 2'b01);
            applyStimulus(RS_ACCESS, 32'hA1);
            daddr[1] = 32'h204;
            pushExp(1'b0, 32'h204, 32'h0, 1'b0, 1'b1, 32'hA2, 2'b11, 2'b01);
            applyStimulus(RS_ACCESS, 32'hA2);
        end
        dREN = '0; cctrans = '0; ccwrite = '0; ramstate = RS_FREE;
        nextCycle();

        // Simultaneous write-backs; core 0 has a second block queued
`ifdef ARB_ROUND_ROBIN_EN
        grantOrder = '{0, 1, 0};
`else
        grantOrder = '{0, 0, 1};
`endif
        nBlk = '{0, 0};
        blkTotal = '{2, 1};
        dWEN = 2'b11;
        daddr[0] = 32'h500; dstore[0] = 32'h50;
        daddr[1] = 32'h600; dstore[1] = 32'h60;
        for (int g = 0; g < 3; g++) begin
            c = grantOrder[g][0];
            nextCycle();
            a = 32'h500 + 32'h100 * 32'(c) + 32'h200 * 32'(nBlk[c]);
            d = 32'h50 + 32'h10 * 32'(c) + 32'h20 * 32'(nBlk[c]);
            pushExp(1'b1, a, d, 1'b0, c, 32'h0, 2'b11, c ? 2'b01 : 2'b10);
            ramstate = RS_ACCESS;
            nextCycle();
            daddr[c] = a + 32'h4; dstore[c] = d + 32'h1;
            pushExp(1'b1, a + 32'h4, d + 32'h1, 1'b0, c, 32'h0, 2'b11, c ? 2'b01 : 2'b10);
            nextCycle();
            ramstate = RS_FREE;
            nBlk[c]++;
            if (nBlk[c] < blkTotal[c]) begin
                daddr[c]  = 32'h500 + 32'h100 * 32'(c) + 32'h200 * 32'(nBlk[c]);
                dstore[c] = 32'h50 + 32'h10 * 32'(c) + 32'h20 * 32'(nBlk[c]);
            end else begin
                dWEN[c] = 1'b0;
            end
        end
        dWEN = '0;
        nextCycle();

        // Requester drops its fill after the first word
        dREN[0] = 1'b1; daddr[0] = 32'h300;
        nextCycle();
        pushExp(1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'hB1, 2'b11, 2'b10);
        applyStimulus(RS_ACCESS, 32'hB1);
        dREN[0] = 1'b0; ramstate = RS_FREE;
        @(negedge CLK);
        checkOutput("abort_no_ren", 32'(ramREN), 32'(1'b0));
        checkOutput("abort_dwait", 32'(dwait), 32'(2'b11));
        nextCycle();
        dREN[0] = 1'b1;
        @(negedge CLK);
        checkOutput("abort_back_idle", 32'(ramREN), 32'(1'b0));
        nextCycle();
        dREN[0] = 1'b0;
        nextCycle();

        // Reset while a cache-to-cache transfer is stalled
        dREN[1] = 1'b1; cctrans[1] = 1'b1; daddr[1] = 32'h400;
        nextCycle();
        cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h400; dstore[0] = 32'h44;
        nextCycle();
        ramstate = RS_BUSY;
        @(negedge CLK);
        checkOutput("c2c_rst_pre_wen", 32'(ramWEN), 32'(1'b1));
        checkOutput("c2c_rst_pre_ccwait", 32'(ccwait), 32'(2'b01));
        nextCycle();
        RST = 1'b1;
        nextCycle();
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("c2c_rst_wen", 32'(ramWEN), 32'(1'b0));
        checkOutput("c2c_rst_ccwait", 32'(ccwait), 32'(2'b00));
        checkOutput("c2c_rst_dwait", 32'(dwait), 32'(2'b11));
        nextCycle();
        dREN = '0; cctrans = '0; ccwrite = '0; ramstate = RS_FREE;
        nextCycle();
        nextCycle();

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
